// File: rtl/svm_rbf_scheduler_pkg.sv
// rtl/svm_rbf_scheduler_pkg.sv - shared SVM widths, ROM word field offsets and scheduler state type
package svm_rbf_scheduler_pkg;

    localparam int SVM_PARAM_WIDTH          = 8;
    localparam int SVM_PARAM_COUNT          = 4;
    localparam int SVM_CLASS_WIDTH          = 3;
    localparam int SVM_COEF_LN_WIDTH        = 12;
    localparam int SVM_COEF_SIGN_WIDTH      = 1;
    localparam int SVM_DISTANCE_WIDTH_INT   = 8;
    localparam int SVM_DISTANCE_WIDTH_FRAC  = 8;
    localparam int SVM_DECISION_COUNT       = 3;

    // Shared by the kernel and the scheduler so both agree on the pipeline depth.
    localparam int SVM_KERNEL_LATENCY       = 15;

    localparam int SVM_X_WIDTH       = SVM_PARAM_WIDTH * SVM_PARAM_COUNT;
    localparam int SVM_SV_WORD_WIDTH = SVM_X_WIDTH + SVM_CLASS_WIDTH + SVM_COEF_LN_WIDTH + SVM_COEF_SIGN_WIDTH;
    localparam int SVM_DIST_WIDTH    = (SVM_DISTANCE_WIDTH_INT + SVM_DISTANCE_WIDTH_FRAC) * SVM_DECISION_COUNT;

    // ROM word is {sv, sv_class, coef_ln, coef_sign}, MSB first; offsets are field LSBs.
    localparam int SV_FIELD_COEF_SIGN_LSB = 0;
    localparam int SV_FIELD_COEF_LN_LSB   = SV_FIELD_COEF_SIGN_LSB + SVM_COEF_SIGN_WIDTH;
    localparam int SV_FIELD_CLASS_LSB     = SV_FIELD_COEF_LN_LSB + SVM_COEF_LN_WIDTH;
    localparam int SV_FIELD_SV_LSB        = SV_FIELD_CLASS_LSB + SVM_CLASS_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/svm_rbf_scheduler_delay_line.sv
// rtl/svm_rbf_scheduler_delay_line.sv - fixed-depth shift register with synchronous clear
module svm_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift din through DEPTH stages; clear wipes every stage at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/svm_rbf_scheduler.sv
// rtl/svm_rbf_scheduler.sv - sequences one feature vector through the RBF kernel and captures distances
module svm_rbf_scheduler
    import svm_rbf_scheduler_pkg::*;
#(
    parameter int SV_COUNT       = 64,
    parameter int SV_ADDR_WIDTH  = 6,
    parameter int MEM_LATENCY    = 1,
    parameter int KERNEL_LATENCY = SVM_KERNEL_LATENCY,
    parameter int X_WIDTH        = SVM_X_WIDTH,
    parameter int SV_WORD_WIDTH  = SVM_SV_WORD_WIDTH,
    parameter int DIST_WIDTH     = SVM_DIST_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           abort,
    input  logic [X_WIDTH-1:0]             x_in,
    input  logic                           x_valid,
    output logic                           x_ready,
    output logic [SV_ADDR_WIDTH-1:0]       sv_addr,
    output logic                           sv_rd_en,
    input  logic [SV_WORD_WIDTH-1:0]       sv_rdata,
    output logic [X_WIDTH-1:0]             k_x,
    output logic [X_WIDTH-1:0]             k_sv,
    output logic [SVM_CLASS_WIDTH-1:0]     k_sv_class,
    output logic [SVM_COEF_LN_WIDTH-1:0]   k_coef_ln,
    output logic [SVM_COEF_SIGN_WIDTH-1:0] k_coef_sign,
    output logic                           k_new_computation,
    output logic                           k_data_valid,
    input  logic [DIST_WIDTH-1:0]          k_distance,
    output logic [DIST_WIDTH-1:0]          result,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic                           busy
);

    localparam logic [SV_ADDR_WIDTH-1:0] LAST_ADDR = SV_ADDR_WIDTH'(SV_COUNT - 1);
    localparam int DRAIN_LOAD = MEM_LATENCY + KERNEL_LATENCY;
    localparam int CNT_W      = $clog2(DRAIN_LOAD + 1);

    sched_state_t     state;
    sched_state_t     state_next;
    logic             accept;
    logic             capture;
    logic             abort_hit;
    logic [CNT_W-1:0] drain_cnt;
    logic [1:0]       dl_in;
    logic [1:0]       dl_out;

    assign abort_hit = abort && (state != ST_IDLE);

    // Next-state decode; abort outside IDLE overrides everything and suppresses capture.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (x_valid && x_ready) begin
                    state_next = ST_ISSUE;
                    accept     = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (sv_addr == LAST_ADDR) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == CNT_W'(1)) begin
                    state_next = ST_DONE;
                    capture    = 1'b1;
                end
            end
            ST_DONE: begin
                if (result_valid && result_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_next = ST_IDLE;
            capture    = 1'b0;
        end
    end

    // State register with Moore outputs registered from the next state, so they stay 0 in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            x_ready      <= 1'b0;
            sv_rd_en     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            x_ready      <= (state_next == ST_IDLE);
            sv_rd_en     <= (state_next == ST_ISSUE);
            result_valid <= (state_next == ST_DONE);
            busy         <= (state_next != ST_IDLE);
        end
    end

    // Datapath: x latch, SV address counter, drain down-counter and result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_x       <= '0;
            result    <= '0;
            sv_addr   <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept) k_x <= x_in;
            if (capture) result <= k_distance;
            if (accept || state_next == ST_IDLE) begin
                sv_addr <= '0;
            end else if (state == ST_ISSUE && state_next == ST_ISSUE) begin
                sv_addr <= sv_addr + SV_ADDR_WIDTH'(1);
            end
            if (state == ST_ISSUE && state_next == ST_DRAIN) begin
                drain_cnt <= CNT_W'(DRAIN_LOAD);
            end else if (state == ST_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - CNT_W'(1);
            end
        end
    end

    // ROM read strobe and first-SV flag follow the ROM data through the read latency.
    assign dl_in = {sv_rd_en, sv_rd_en && (sv_addr == '0)};

    svm_delay_line #(
        .WIDTH (2),
        .DEPTH (MEM_LATENCY)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .clear (abort_hit),
        .din   (dl_in),
        .dout  (dl_out)
    );

    assign k_data_valid      = dl_out[1];
    assign k_new_computation = dl_out[0];

    assign k_sv        = sv_rdata[SV_FIELD_SV_LSB +: X_WIDTH];
    assign k_sv_class  = sv_rdata[SV_FIELD_CLASS_LSB +: SVM_CLASS_WIDTH];
    assign k_coef_ln   = sv_rdata[SV_FIELD_COEF_LN_LSB +: SVM_COEF_LN_WIDTH];
    assign k_coef_sign = sv_rdata[SV_FIELD_COEF_SIGN_LSB +: SVM_COEF_SIGN_WIDTH];

endmodule
